// File: rtl/alu_issue_unit_if.sv
// Instruction handshake, ALU drive/result and write-back signals of alu_issue_unit.
// Handshake: a word transfers on a rising edge where instr_valid && instr_ready; the source holds instr stable until then.
interface alu_issue_unit_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_s;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  modport master (
    output instr_valid, instr, alu_s,
    input  instr_ready, alu_a, alu_b, alu_sel, wb_valid, wb_rd, wb_data, illegal
  );

  modport slave (
    input  instr_valid, instr, alu_s,
    output instr_ready, alu_a, alu_b, alu_sel, wb_valid, wb_rd, wb_data, illegal
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Single-issue RV32I ALU front-end: decodes OP/OP-IMM/LUI, drives an external ALU,
// captures its result and writes it back to a 32x32 register file.
module alu_issue_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_issue_unit_if.slave bus,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  state_t state, state_nx;

  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] alu_a_q, alu_b_q, wb_data_q;
  logic [3:0]      alu_sel_q;
  logic [4:0]      rd_q, wb_rd_q;

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            alt, dec_ok, accept;
  logic [XLEN-1:0] dec_a, dec_b;
  logic [3:0]      dec_sel;

  assign opcode  = bus.instr[6:0];
  assign rd      = bus.instr[11:7];
  assign f3      = bus.instr[14:12];
  assign rs1     = bus.instr[19:15];
  assign rs2     = bus.instr[24:20];
  assign f7      = bus.instr[31:25];
  assign alt     = (f7 == F7_ALT);
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

  // funct3 maps onto the ALU select the same way for OP and OP-IMM; only
  // funct3 0 (OP only) and 5 take the alternate encoding from funct7.
  always_comb begin
    dec_ok  = 1'b0;
    dec_a   = rs1_val;
    dec_b   = rs2_val;
    dec_sel = 4'd0;
    case (f3)
      3'd0:    dec_sel = (opcode == OP_R && alt) ? 4'd1 : 4'd0;
      3'd1:    dec_sel = 4'd2;
      3'd2:    dec_sel = 4'd3;
      3'd3:    dec_sel = 4'd4;
      3'd4:    dec_sel = 4'd5;
      3'd5:    dec_sel = alt ? 4'd7 : 4'd6;
      3'd6:    dec_sel = 4'd8;
      default: dec_sel = 4'd9;
    endcase
    case (opcode)
      OP_R: dec_ok = (f7 == 7'd0) || (alt && (f3 == 3'd0 || f3 == 3'd5));
      OP_I: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          dec_b  = {27'b0, rs2};
          dec_ok = (f7 == 7'd0) || (alt && f3 == 3'd5);
        end else begin
          dec_b  = {{20{bus.instr[31]}}, bus.instr[31:20]};
          dec_ok = 1'b1;
        end
      end
      OP_LUI: begin
        dec_a   = '0;
        dec_b   = {bus.instr[31:12], 12'b0};
        dec_sel = 4'd0;
        dec_ok  = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  assign bus.instr_ready = (state == IDLE) && !rst;
  assign accept          = bus.instr_valid && bus.instr_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = dec_ok ? EXEC : ERR;
      EXEC:    state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      rd_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      if (accept && dec_ok) begin
        alu_a_q   <= dec_a;
        alu_b_q   <= dec_b;
        alu_sel_q <= dec_sel;
        rd_q      <= rd;
      end
      if (state == EXEC) begin
        wb_data_q <= bus.alu_s;
        wb_rd_q   <= rd_q;
      end
      // x0 is hardwired: its slot stays zero from reset.
      if (state == WB && wb_rd_q != 5'd0) regs[wb_rd_q] <= wb_data_q;
    end
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_sel  = alu_sel_q;
  assign bus.wb_valid = (state == WB);
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.illegal  = (state == ERR);
  assign dbg_data     = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];
  assign dbg_state    = state;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: architectural model with per-cycle comparison plus
// directed instructions carrying hand-computed results.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;
  logic [1:0]  dbg_state;

  alu_issue_unit_if bus ();

  alu_issue_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- ALU (stands in for mainALU #(32)) ----------------
  function automatic logic [31:0] alu_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    case (sel)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return a | b;
      4'd9:    return a & b;
      default: return 32'd0;
    endcase
  endfunction

  always_comb bus.alu_s = alu_op(bus.alu_sel, bus.alu_a, bus.alu_b);

  // ---------------- scoreboard bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- architectural model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] exp_q [$];

  // Mnemonic-level decode: legal?, operands and select for the ALU.
  function automatic void model_decode(input logic [31:0] w, output logic ok,
                                       output logic [31:0] a, output logic [31:0] b,
                                       output logic [3:0] sel);
    logic [31:0] x, y, imm, sh;
    logic [2:0]  f3;
    logic [6:0]  f7;
    x   = m_regs[w[19:15]];
    y   = m_regs[w[24:20]];
    imm = {{20{w[31]}}, w[31:20]};
    sh  = {27'b0, w[24:20]};
    f3  = w[14:12];
    f7  = w[31:25];
    ok  = 1'b0;
    a   = x;
    b   = y;
    sel = 4'd0;
    case (w[6:0])
      7'h33: begin
        ok = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: sel = 4'd0;
          {7'h20, 3'd0}: sel = 4'd1;
          {7'h00, 3'd1}: sel = 4'd2;
          {7'h00, 3'd2}: sel = 4'd3;
          {7'h00, 3'd3}: sel = 4'd4;
          {7'h00, 3'd4}: sel = 4'd5;
          {7'h00, 3'd5}: sel = 4'd6;
          {7'h20, 3'd5}: sel = 4'd7;
          {7'h00, 3'd6}: sel = 4'd8;
          {7'h00, 3'd7}: sel = 4'd9;
          default:       ok  = 1'b0;
        endcase
      end
      7'h13: begin
        b  = imm;
        ok = 1'b1;
        case (f3)
          3'd0: sel = 4'd0;
          3'd2: sel = 4'd3;
          3'd3: sel = 4'd4;
          3'd4: sel = 4'd5;
          3'd6: sel = 4'd8;
          3'd7: sel = 4'd9;
          3'd1: begin b = sh; sel = 4'd2; ok = (f7 == 7'h00); end
          default: begin
            b   = sh;
            sel = (f7 == 7'h20) ? 4'd7 : 4'd6;
            ok  = (f7 == 7'h00) || (f7 == 7'h20);
          end
        endcase
      end
      7'h37: begin a = 32'd0; b = {w[31:12], 12'b0}; sel = 4'd0; ok = 1'b1; end
      default: ok = 1'b0;
    endcase
  endfunction

  // ---------------- per-cycle compare process ----------------
  bit          chk_en   = 1'b0;
  bit          rst_prev = 1'b1;
  int          cyc      = 0;
  int          ready_at = 0;
  int          exec_at  = -1;
  int          wb_at    = -1;
  int          ill_at   = -1;
  logic [31:0] m_a = '0, m_b = '0, m_wbd = '0, pa, pb;
  logic [3:0]  m_sel = '0, psel;
  logic [4:0]  m_wbrd = '0, pend_rd = '0;
  logic        pok;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        exp_q.delete();
        m_a = '0; m_b = '0; m_sel = '0; m_wbrd = '0; m_wbd = '0;
        exec_at = -1; wb_at = -1; ill_at = -1; ready_at = cyc;
      end
      if (cyc == exec_at) begin m_a = pa; m_b = pb; m_sel = psel; end
      if (cyc == wb_at) begin m_wbrd = pend_rd; m_wbd = exp_q.pop_front(); end
      if (chk_en) begin
        check("cyc instr_ready", 32'(bus.instr_ready), 32'(!rst && cyc >= ready_at));
        check("cyc wb_valid",    32'(bus.wb_valid),    32'(cyc == wb_at));
        check("cyc illegal",     32'(bus.illegal),     32'(cyc == ill_at));
        check("cyc alu_a",       bus.alu_a,            m_a);
        check("cyc alu_b",       bus.alu_b,            m_b);
        check("cyc alu_sel",     32'(bus.alu_sel),     32'(m_sel));
        check("cyc wb_rd",       32'(bus.wb_rd),       32'(m_wbrd));
        check("cyc wb_data",     bus.wb_data,          m_wbd);
        check("cyc dbg_data",    dbg_data,             m_regs[dbg_addr]);
      end
      if (!rst && cyc >= ready_at && bus.instr_valid) begin
        model_decode(bus.instr, pok, pa, pb, psel);
        if (pok) begin
          pend_rd = bus.instr[11:7];
          exp_q.push_back(alu_op(psel, pa, pb));
          exec_at  = cyc + 1;
          wb_at    = cyc + 2;
          ready_at = cyc + 3;
        end else begin
          ill_at   = cyc + 1;
          ready_at = cyc + 2;
        end
      end
      if (cyc == wb_at && m_wbrd != 5'd0) m_regs[m_wbrd] = m_wbd;
      rst_prev = rst;
      cyc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept(input string nm, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.instr_ready) got = 1'b1;
    end
    if (!got) check({nm, " accept timeout"}, 32'd0, 32'd1);
  endtask

  // Issues one word, checks the T+1/T+2/T+3 behaviour against literals,
  // then reads chk_reg through the debug port.
  task automatic issue(input string nm, input logic [31:0] w, input bit legal,
                       input logic [3:0] sel, input logic [31:0] wbd,
                       input logic [4:0] chk_reg, input logic [31:0] regv);
    bit got;
    @(posedge clk); #1;
    bus.instr = w;
    bus.instr_valid = 1'b1;
    wait_accept(nm, got);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    if (!got) return;
    @(negedge clk);
    check({nm, " ready T+1"}, 32'(bus.instr_ready), 32'd0);
    if (legal) begin
      check({nm, " alu_sel"}, 32'(bus.alu_sel), 32'(sel));
      @(negedge clk);
      check({nm, " wb_valid"}, 32'(bus.wb_valid), 32'd1);
      check({nm, " wb_rd"},    32'(bus.wb_rd),    32'(w[11:7]));
      check({nm, " wb_data"},  bus.wb_data,       wbd);
    end else begin
      check({nm, " illegal"},  32'(bus.illegal),  32'd1);
      check({nm, " no wb"},    32'(bus.wb_valid), 32'd0);
    end
    @(posedge clk); #1;
    dbg_addr = chk_reg;
    @(negedge clk);
    check({nm, " ready after"}, 32'(bus.instr_ready), 32'd1);
    check({nm, " reg"},         dbg_data,             regv);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] b2b_words [3];
  int          acc_at [3];
  int          n_acc;
  int          k;
  bit          got;

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    b2b_words[0] = 32'h00100393;  // ADDI x7,x0,1
    b2b_words[1] = 32'h00238413;  // ADDI x8,x7,2
    b2b_words[2] = 32'h001444B3;  // XOR  x9,x8,x1
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset ready",    32'(bus.instr_ready), 32'd1);
    check("reset alu_a",    bus.alu_a,            32'd0);
    check("reset alu_sel",  32'(bus.alu_sel),     32'd0);
    check("reset wb_valid", 32'(bus.wb_valid),    32'd0);
    check("reset wb_data",  bus.wb_data,          32'd0);
    check("reset illegal",  32'(bus.illegal),     32'd0);

    issue("addi_x1",  32'h00500093, 1'b1, 4'd0, 32'h00000005, 5'd1, 32'h00000005);
    issue("addi_x2",  32'hFFD00113, 1'b1, 4'd0, 32'hFFFFFFFD, 5'd2, 32'hFFFFFFFD);
    issue("sub_x3",   32'h402081B3, 1'b1, 4'd1, 32'h00000008, 5'd3, 32'h00000008);
    issue("slt_x4",   32'h00112233, 1'b1, 4'd3, 32'h00000001, 5'd4, 32'h00000001);
    issue("srai_x5",  32'h40115293, 1'b1, 4'd7, 32'hFFFFFFFE, 5'd5, 32'hFFFFFFFE);
    issue("lui_x6",   32'h12345337, 1'b1, 4'd0, 32'h12345000, 5'd6, 32'h12345000);
    issue("addi_x0",  32'h00700013, 1'b1, 4'd0, 32'h00000007, 5'd0, 32'h00000000);
    issue("ill_op",   32'h0000007F, 1'b0, 4'd0, 32'h0,        5'd1, 32'h00000005);
    issue("ill_slli", 32'h40109093, 1'b0, 4'd0, 32'h0,        5'd1, 32'h00000005);

    // Valid held high across three dependent words.
    @(posedge clk); #1;
    bus.instr = b2b_words[0];
    bus.instr_valid = 1'b1;
    n_acc = 0;
    k = 0;
    for (int i = 0; i < 40 && n_acc < 3; i++) begin
      @(negedge clk);
      k++;
      if (bus.instr_ready) begin
        acc_at[n_acc] = k;
        n_acc++;
        @(posedge clk); #1;
        if (n_acc < 3) bus.instr = b2b_words[n_acc];
        else bus.instr_valid = 1'b0;
      end
    end
    bus.instr_valid = 1'b0;
    check("b2b accepts", 32'(n_acc), 32'd3);
    if (n_acc == 3) begin
      check("b2b gap 0-1", 32'(acc_at[1] - acc_at[0]), 32'd3);
      check("b2b gap 1-2", 32'(acc_at[2] - acc_at[1]), 32'd3);
    end
    repeat (2) @(posedge clk);
    #1 dbg_addr = 5'd8;
    @(negedge clk);
    check("b2b x8", dbg_data, 32'h00000003);
    @(posedge clk); #1 dbg_addr = 5'd9;
    @(negedge clk);
    check("b2b x9", dbg_data, 32'h00000006);

    // Reset while the instruction is in EXEC.
    @(posedge clk); #1;
    bus.instr = 32'h00A00513;  // ADDI x10,x0,10
    bus.instr_valid = 1'b1;
    wait_accept("rst_exec", got);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_exec alu_b in EXEC", bus.alu_b, 32'h0000000A);
    @(posedge clk); #1;
    rst = 1'b0;
    dbg_addr = 5'd1;
    @(negedge clk);
    check("rst_exec no wb",  32'(bus.wb_valid),    32'd0);
    check("rst_exec alu_a",  bus.alu_a,            32'd0);
    check("rst_exec alu_b",  bus.alu_b,            32'd0);
    check("rst_exec wb_rd",  32'(bus.wb_rd),       32'd0);
    check("rst_exec wb_data", bus.wb_data,         32'd0);
    check("rst_exec x1",     dbg_data,             32'd0);
    check("rst_exec ready",  32'(bus.instr_ready), 32'd1);

    issue("post_rst", 32'h00500093, 1'b1, 4'd0, 32'h00000005, 5'd1, 32'h00000005);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Single-issue execute front-end that drives the team's 32-bit combinational ALU (`mainALU #(32)`). It accepts RV32I integer instruction words over a valid/ready handshake and decodes them into `alu_a`, `alu_b` and `alu_sel`. It reads operands from an internal 32x32 register file, captures the ALU result and writes it back. It sits upstream of the ALU and closes the loop on its result port.

## Interface

- `XLEN`, 32, datapath width; only 32 supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction word present.
- `instr_ready`  out  1  unit can accept an instruction this cycle.
- `instr`  in  32  RV32I instruction word.
- `alu_a`  out  32  ALU operand A (registered).
- `alu_b`  out  32  ALU operand B (registered).
- `alu_sel`  out  4  ALU operation select (registered).
- `alu_s`  in  32  ALU result (combinational from `alu_a`/`alu_b`/`alu_sel`).
- `wb_valid`  out  1  one-cycle retire pulse.
- `wb_rd`  out  5  retired destination register.
- `wb_data`  out  32  retired result.
- `illegal`  out  1  one-cycle pulse: rejected instruction.
- `dbg_addr`  in  5  debug register-file read address.
- `dbg_data`  out  32  combinational read of `regs[dbg_addr]`; returns 0 for x0.

## Operation

- ALU select encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - Codes 10–12 are never issued.
- Supported opcodes:
  - **R-type `0110011`:** ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
    - funct7 must be `0000000`, or `0100000` only for SUB and SRA.
  - **I-type `0010011`:** ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
    - `alu_b` is the sign-extended `imm[11:0]`.
    - For shifts, `alu_b = {27'b0, instr[24:20]}`.
    - `instr[31:25]` must be `0000000`, or `0100000` for SRAI only.
  - **LUI `0110111`:** `alu_a = 0`, `alu_b = {instr[31:12], 12'b0}`, `alu_sel = ADD`.
- Every other opcode or funct combination is illegal.
  - No ALU update, no write-back, `illegal` pulses.
- Register file:
  - 32x32; x0 reads 0 always; writes to x0 are discarded.
  - Operands are read in the accept cycle.
- FSM states: IDLE, EXEC, WB, ERR.
  - **IDLE:** `instr_ready = 1`. On `instr_valid`:
    - legal → latch `alu_a`/`alu_b`/`alu_sel`/rd, go to EXEC;
    - illegal → go to ERR.
  - **EXEC:** `instr_ready = 0`. Capture `alu_s` into the result register at the clock edge, then go to WB.
  - **WB:** `wb_valid = 1`, `wb_rd`/`wb_data` valid. Write the register file (if rd ≠ 0) at the clock edge, then go to IDLE.
  - **ERR:** `illegal = 1`, `instr_ready = 0`, then go to IDLE.
- `alu_a`/`alu_b`/`alu_sel`/`wb_rd`/`wb_data` hold their last values outside their active states.
- All arithmetic is modulo 2^32. Signedness follows `alu_sel` only.

## Timing

- Accept edge ends cycle T (`instr_valid && instr_ready`).
- **Legal instruction:**
  - cycle T+1: EXEC, ALU inputs stable;
  - cycle T+2: WB pulse;
  - cycle T+3: `instr_ready = 1`.
  - Throughput is one instruction per 3 cycles.
- **Illegal instruction:** `illegal = 1` in T+1, `instr_ready = 1` in T+2.
- **Back-to-back dependency:** a write at the end of T+2 is visible to an instruction accepted in T+3. No forwarding needed.
- `instr_valid` while `instr_ready = 0`: ignored, not consumed. The source must hold the word.
- **Reset behaviour:**
  - `rst` asserted in any state → IDLE on the next edge, in-flight instruction dropped.
  - All 32 registers cleared to 0.
  - `alu_a = alu_b = 0`, `alu_sel = 0`, `wb_valid = 0`, `wb_rd = 0`, `wb_data = 0`, `illegal = 0`.
  - `instr_ready = 1` in the first cycle after `rst` deasserts.
- `rst` has priority over the handshake. An instruction presented during reset is not accepted.

## Test plan

The bench connects `mainALU #(32)` between `alu_*` and `alu_s`.

- **ADDI chain:** `0x00500093` (ADDI x1,x0,5), then `0xFFD00113` (ADDI x2,x0,-3).
  - WB pulses: rd=1 data=`0x00000005`, then rd=2 data=`0xFFFFFFFD`.
  - `instr_ready` low for exactly 2 cycles after each accept.
- **Dependent R-type:**
  - `0x402081B3` (SUB x3,x1,x2) → x3=`0x00000008`.
  - `0x00112233` (SLT x4,x2,x1) → x4=1.
  - Check `alu_sel` = 1 and 3 in the respective EXEC cycles.
- **Shifts/LUI:**
  - `0x40115293` (SRAI x5,x2,1) → `0xFFFFFFFE`.
  - `0x12345337` (LUI x6) → `0x12345000`.
- **x0 and illegal:**
  - `0x00700013` (ADDI x0,x0,7) → `wb_valid` with rd=0; `dbg_data` for x0 stays 0.
  - `0x0000007F` and `0x40109093` (SLLI with bad funct7): each gives a single `illegal` pulse in T+1, no `wb_valid`, registers unchanged.
- **Handshake/reset:**
  - Hold `instr_valid` high continuously with 3 instructions → exactly 3 accepts, one every 3 cycles.
  - Assert `rst` during EXEC → no WB pulse, all outputs 0, `dbg_data` for x1 reads 0, `instr_ready = 1` one cycle after `rst` drops.
